bcd_score_sequencer: RTL



---
 rtl/bcd_score_sequencer_if.sv | 23 ++
 rtl/bcd_score_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bcd_score_sequencer_if.sv
// Request/response bundle between the game-logic event source and the BCD score sequencer.
// The master side issues add/clear requests; the slave side reports progress and the score.
interface bcd_score_sequencer_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  clear;
    logic                  add_req;
    logic [3:0]            add_val;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   score;
    logic                  overflow;

    modport master (
        output clear, add_req, add_val,
        input  busy, done, score, overflow
    );

    modport slave (
        input  clear, add_req, add_val,
        output busy, done, score, overflow
    );
endinterface

// File: rtl/bcd_score_sequencer.sv
// Multi-digit BCD score accumulator. A single 4-bit BCD digit adder is time-shared across
// all score digits, one digit per clock, with the decimal carry rippled through a register.
// Optional build macro: SCORE_SATURATE_EN -- when defined, a carry out of the top digit
// loads the score with all nines; otherwise the score wraps modulo 10^DIGITS.
// In both builds the sticky overflow flag is set on that carry.
module bcd_score_sequencer #(
    parameter int unsigned DIGITS = 4
) (
    input logic                  clk,
    input logic                  nrst,
    bcd_score_sequencer_if.slave bus
);

    localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned ScoreW = 4 * DIGITS;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ScoreW-1:0]   score_q, score_d;
    logic                overflow_q, overflow_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [3:0]          operand_q, operand_d;
    logic                busy_q, busy_d;

    logic [3:0]          digit_a;
    logic [3:0]          digit_b;
    logic [4:0]          digit_tmp;
    logic [3:0]          digit_sum;
    logic                digit_cout;

    // Shared BCD digit adder operating on the digit selected by idx_q.
    always_comb begin
        digit_a = 4'd0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (idx_q == IdxW'(k)) begin
                digit_a = score_q[4*k +: 4];
            end
        end
        digit_b   = (idx_q == '0) ? operand_q : 4'd0;
        digit_tmp = {1'b0, digit_a} + {1'b0, digit_b} + {4'd0, carry_q};
        // temp - 10 taken modulo 16 equals temp[3:0] + 6 for temp in 10..19.
        if (digit_tmp > 5'd9) begin
            digit_sum  = digit_tmp[3:0] + 4'd6;
            digit_cout = 1'b1;
        end else begin
            digit_sum  = digit_tmp[3:0];
            digit_cout = 1'b0;
        end
    end

    // Next-state, datapath update and abort handling.
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        overflow_d = overflow_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        operand_d  = operand_q;

        unique case (state_q)
            StIdle: begin
                if (bus.clear) begin
                    score_d    = '0;
                    overflow_d = 1'b0;
                end else if (bus.add_req) begin
                    operand_d = (bus.add_val > 4'd9) ? 4'd9 : bus.add_val;
                    idx_d     = '0;
                    carry_d   = 1'b0;
                    state_d   = StAdd;
                end
            end
            StAdd: begin
                for (int k = 0; k < int'(DIGITS); k++) begin
                    if (idx_q == IdxW'(k)) begin
                        score_d[4*k +: 4] = digit_sum;
                    end
                end
                carry_d = digit_cout;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (carry_q) begin
                    overflow_d = 1'b1;
`ifdef SCORE_SATURATE_EN
                    score_d = {DIGITS{4'h9}};
`else
                    score_d = score_q;
`endif
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Clear mid-operation abandons the add; any add_req alongside it is dropped.
        if (bus.clear && (state_q != StIdle)) begin
            score_d    = '0;
            overflow_d = 1'b0;
            state_d    = StIdle;
        end
    end

    // busy follows the registered state so it rises one cycle after capture.
    always_comb begin
        busy_d = (state_d != StIdle);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= StIdle;
            score_q    <= '0;
            overflow_q <= 1'b0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            operand_q  <= 4'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            overflow_q <= overflow_d;
            idx_q      <= idx_d;
            carry_q    <= carry_d;
            operand_q  <= operand_d;
            busy_q     <= busy_d;
        end
    end

    // Outputs; an aborting clear suppresses the done pulse.
    always_comb begin
        bus.busy     = busy_q;
        bus.done     = (state_q == StDone) && !bus.clear;
        bus.score    = score_q;
        bus.overflow = overflow_q;
    end

endmodule
